// File: rtl/pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gen_if
// Brief    : Control/status bundle for pulse_gen (optional abort with
//            PULSE_GEN_ABORT_EN).
// Revision : 1.0
// ============================================================================
interface pulse_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] act_cycles;
    logic [CNT_W-1:0] gap_cycles;
    logic [7:0]       pulse_num;
    logic             sig_out;
    logic             busy;
    logic             done;
`ifdef PULSE_GEN_ABORT_EN
    logic             abort;

    modport slave  (input  start, act_cycles, gap_cycles, pulse_num, abort,
                    output sig_out, busy, done);
    modport master (output start, act_cycles, gap_cycles, pulse_num, abort,
                    input  sig_out, busy, done);
`else
    modport slave  (input  start, act_cycles, gap_cycles, pulse_num,
                    output sig_out, busy, done);
    modport master (output start, act_cycles, gap_cycles, pulse_num,
                    input  sig_out, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gen
// Brief    : Programmable pulse-train generator (ACT/GAP phases, N pulses).
//            Optional abort input enabled by macro PULSE_GEN_ABORT_EN.
// Revision : 1.0
// ============================================================================
module pulse_gen #(
    parameter int   CNT_W      = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pulse_gen_if.slave pg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACT  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_zero = '0;
    localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       num_q, num_d;
    logic [7:0]       sent_q, sent_d;
    logic             sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_hit;

`ifdef PULSE_GEN_ABORT_EN
    assign abort_hit = pg.abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            sent_q  <= '0;
            sig_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Lengths are latched already clamped to >=1, so "len-1" never underflows
    // and the up-counter stops one short of the all-ones value at most.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        sent_d  = sent_q;
        unique case (state_q)
            S_IDLE: begin
                if (pg.start) begin
                    act_d   = (pg.act_cycles == c_zero) ? c_one : pg.act_cycles;
                    gap_d   = (pg.gap_cycles == c_zero) ? c_one : pg.gap_cycles;
                    num_d   = pg.pulse_num;
                    cnt_d   = '0;
                    sent_d  = '0;
                    state_d = (pg.pulse_num == 8'd0) ? S_DONE : S_ACT;
                end
            end
            S_ACT: begin
                if (abort_hit) begin
                    state_d = S_DONE;
                end else if (cnt_q == act_q - c_one) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_GAP: begin
                if (abort_hit) begin
                    state_d = S_DONE;
                end else if (cnt_q == gap_q - c_one) begin
                    cnt_d  = '0;
                    sent_d = sent_q + 8'd1;
                    state_d = (({1'b0, sent_q} + 9'd1) < {1'b0, num_q}) ? S_ACT : S_DONE;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are a function of the next state so they leave registers.
        sig_d  = (state_d == S_ACT) ? ~IDLE_LEVEL : IDLE_LEVEL;
        busy_d = (state_d == S_ACT) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign pg.sig_out = sig_q;
    assign pg.busy    = busy_q;
    assign pg.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_gen
// Brief    : Directed self-checking bench for pulse_gen.
// Revision : 1.0
// ============================================================================
module tb_pulse_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_gen_if #(.CNT_W(16)) pg ();
    pulse_gen_if #(.CNT_W(3))  ps ();

    pulse_gen #(.CNT_W(16), .IDLE_LEVEL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg.slave)
    );

    pulse_gen #(.CNT_W(3), .IDLE_LEVEL(1'b1)) dut_small (
        .clk (clk),
        .rst (rst),
        .pg  (ps.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one train, follow it cycle by cycle, compare against the
    // phase model and against hand-derived totals.
    task automatic run_train(input string tag, input int a, input int g, input int p,
                             input int disturb_k, input int exp_busy,
                             input int exp_edges, input int exp_done_k);
        int   ap, gp, period, total;
        int   busy_n, falls, rises, dones, done_k;
        logic prev, e_sig, e_busy, e_done;
        ap     = (a == 0) ? 1 : a;
        gp     = (g == 0) ? 1 : g;
        period = ap + gp;
        total  = p * period;
        busy_n = 0; falls = 0; rises = 0; dones = 0; done_k = -1;
        prev   = pg.sig_out;
        pg.act_cycles = 16'(a);
        pg.gap_cycles = 16'(g);
        pg.pulse_num  = 8'(p);
        pg.start      = 1'b1;
        tick();
        pg.start = 1'b0;
        for (int k = 1; k <= total + 3; k++) begin
            e_busy = (k <= total);
            e_done = (k == total + 1);
            e_sig  = (k <= total && ((k - 1) % period) < ap) ? 1'b0 : 1'b1;
            check({tag, "_sig"},  32'(pg.sig_out), 32'(e_sig));
            check({tag, "_busy"}, 32'(pg.busy),    32'(e_busy));
            check({tag, "_done"}, 32'(pg.done),    32'(e_done));
            if (pg.busy) busy_n++;
            if (pg.done) begin dones++; done_k = k; end
            if (prev == 1'b1 && pg.sig_out == 1'b0) falls++;
            if (prev == 1'b0 && pg.sig_out == 1'b1) rises++;
            prev = pg.sig_out;
            if (k == disturb_k) begin
                pg.start      = 1'b1;
                pg.act_cycles = 16'd1;
                pg.gap_cycles = 16'd7;
                pg.pulse_num  = 8'd200;
            end else begin
                pg.start = 1'b0;
            end
            tick();
        end
        pg.start = 1'b0;
        check({tag, "_busy_total"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_falls"},      32'(falls),  32'(exp_edges));
        check({tag, "_rises"},      32'(rises),  32'(exp_edges));
        check({tag, "_done_count"}, 32'(dones),  32'd1);
        check({tag, "_done_cycle"}, 32'(done_k), 32'(exp_done_k));
    endtask

    initial begin
        int busy_n, done_k, falls;
        logic prev;
        rst           = 1'b1;
        pg.start      = 1'b0;
        pg.act_cycles = '0;
        pg.gap_cycles = '0;
        pg.pulse_num  = '0;
        ps.start      = 1'b0;
        ps.act_cycles = '0;
        ps.gap_cycles = '0;
        ps.pulse_num  = '0;
`ifdef PULSE_GEN_ABORT_EN
        pg.abort = 1'b0;
        ps.abort = 1'b0;
`endif
        // Reset held 10 cycles, then idle with no edges.
        for (int i = 0; i < 10; i++) tick();
        check("rst_sig",  32'(pg.sig_out), 32'd1);
        check("rst_busy", 32'(pg.busy),    32'd0);
        check("rst_done", 32'(pg.done),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_sig",  32'(pg.sig_out), 32'd1);
            check("idle_busy", 32'(pg.busy),    32'd0);
            check("idle_done", 32'(pg.done),    32'd0);
        end

        run_train("single",   10, 10, 1, 0, 20, 1, 21);
        run_train("four",      3,  2, 4, 0, 20, 4, 21);
        run_train("zero_len",  0,  0, 2, 0,  4, 2,  5);
        run_train("zero_num",  5,  5, 0, 0,  0, 0,  1);
        run_train("restart_gap", 3, 2, 3, 4, 15, 3, 16);
        run_train("restart_done", 2, 1, 2, 7, 6, 2, 7);

        // Reset in the middle of ACT: immediate idle level, no done afterwards.
        pg.act_cycles = 16'd5;
        pg.gap_cycles = 16'd5;
        pg.pulse_num  = 8'd3;
        pg.start      = 1'b1;
        tick();
        pg.start = 1'b0;
        tick();
        check("midrst_pre_sig", 32'(pg.sig_out), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("midrst_async_sig",  32'(pg.sig_out), 32'd1);
        check("midrst_async_busy", 32'(pg.busy),    32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", 32'(pg.done), 32'd0);
            check("midrst_idle",    32'(pg.busy), 32'd0);
        end
        run_train("after_rst", 2, 1, 2, 0, 6, 2, 7);

        // All-ones durations on a 3-bit instance: 7 + 7 busy cycles.
        ps.act_cycles = 3'h7;
        ps.gap_cycles = 3'h7;
        ps.pulse_num  = 8'd1;
        ps.start      = 1'b1;
        tick();
        ps.start = 1'b0;
        busy_n = 0;
        done_k = -1;
        for (int k = 1; k <= 18; k++) begin
            if (k == 7) check("small_act_end", 32'(ps.sig_out), 32'd0);
            if (k == 8) check("small_gap_start", 32'(ps.sig_out), 32'd1);
            if (ps.busy) busy_n++;
            if (ps.done) done_k = k;
            tick();
        end
        check("small_busy_total", 32'(busy_n), 32'd14);
        check("small_done_cycle", 32'(done_k), 32'd15);

`ifdef PULSE_GEN_ABORT_EN
        // Abort while idle has no effect.
        pg.abort = 1'b1;
        tick();
        tick();
        check("abort_idle_busy", 32'(pg.busy), 32'd0);
        check("abort_idle_done", 32'(pg.done), 32'd0);
        pg.abort = 1'b0;
        // 5-pulse train, act=2 gap=3: second GAP spans cycles 8..10.
        pg.act_cycles = 16'd2;
        pg.gap_cycles = 16'd3;
        pg.pulse_num  = 8'd5;
        pg.start      = 1'b1;
        tick();
        pg.start = 1'b0;
        busy_n = 0;
        done_k = -1;
        falls  = 0;
        prev   = pg.sig_out;
        for (int k = 1; k <= 20; k++) begin
            if (pg.busy) busy_n++;
            if (pg.done) done_k = k;
            if (prev == 1'b1 && pg.sig_out == 1'b0) falls++;
            prev = pg.sig_out;
            if (k == 9) begin
                check("abort_done_sig",  32'(pg.sig_out), 32'd1);
                check("abort_done_busy", 32'(pg.busy),    32'd0);
            end
            pg.abort = (k == 8);
            tick();
        end
        pg.abort = 1'b0;
        check("abort_busy_total", 32'(busy_n), 32'd8);
        check("abort_done_cycle", 32'(done_k), 32'd9);
        check("abort_falls",      32'(falls),  32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
